// File: rtl/decode_issue_rename_unit_if.sv
// Signal bundle around the decode/rename/issue stage: fetch input, execute-pipe
// issue, complete/commit notifications in, squash notification out.
interface decode_issue_rename_unit_if #(
    parameter int p_num_pipes     = 3,
    parameter int p_seq_num_bits  = 5,
    parameter int p_num_phys_regs = 36
);
    localparam int P = $clog2(p_num_phys_regs);

    logic                      F_val;
    logic                      F_rdy;
    logic [31:0]               F_inst;
    logic [31:0]               F_pc;
    logic [p_seq_num_bits-1:0] F_seq_num;

    // Payload is shared by all pipes; only the selected pipe sees Ex_val.
    logic [p_num_pipes-1:0]    Ex_val;
    logic [p_num_pipes-1:0]    Ex_rdy;
    logic [31:0]               Ex_pc;
    logic [p_seq_num_bits-1:0] Ex_seq_num;
    logic [31:0]               Ex_op1;
    logic [31:0]               Ex_op2;
    logic [31:0]               Ex_op3;
    logic [4:0]                Ex_waddr;
    logic [P-1:0]              Ex_preg;
    logic [P-1:0]              Ex_ppreg;
    logic [2:0]                Ex_uop;

    logic                      complete_val;
    logic [p_seq_num_bits-1:0] complete_seq_num;
    logic [4:0]                complete_waddr;
    logic [31:0]               complete_wdata;
    logic                      complete_wen;
    logic [P-1:0]              complete_preg;

    logic                      commit_val;
    logic [31:0]               commit_pc;
    logic [p_seq_num_bits-1:0] commit_seq_num;
    logic [4:0]                commit_waddr;
    logic [31:0]               commit_wdata;
    logic                      commit_wen;
    logic [P-1:0]              commit_ppreg;

    logic                      squash_val;
    logic [p_seq_num_bits-1:0] squash_seq_num;
    logic [31:0]               squash_target;

    modport master (
        input  F_val, F_inst, F_pc, F_seq_num, Ex_rdy,
        input  complete_val, complete_seq_num, complete_waddr, complete_wdata,
        input  complete_wen, complete_preg,
        input  commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata,
        input  commit_wen, commit_ppreg,
        output F_rdy, Ex_val, Ex_pc, Ex_seq_num, Ex_op1, Ex_op2, Ex_op3,
        output Ex_waddr, Ex_preg, Ex_ppreg, Ex_uop,
        output squash_val, squash_seq_num, squash_target
    );

    modport slave (
        output F_val, F_inst, F_pc, F_seq_num, Ex_rdy,
        output complete_val, complete_seq_num, complete_waddr, complete_wdata,
        output complete_wen, complete_preg,
        output commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata,
        output commit_wen, commit_ppreg,
        input  F_rdy, Ex_val, Ex_pc, Ex_seq_num, Ex_op1, Ex_op2, Ex_op3,
        input  Ex_waddr, Ex_preg, Ex_ppreg, Ex_uop,
        input  squash_val, squash_seq_num, squash_target
    );
endinterface

// File: rtl/decode_issue_rename_unit.sv
// TinyRV1 decode/rename/issue: one instruction per cycle, map table + free-list
// renaming, physical register file read with complete bypass, lowest-index pipe issue.
module decode_issue_rename_unit #(
    parameter int p_num_pipes     = 3,
    parameter int p_seq_num_bits  = 5,
    parameter int p_num_phys_regs = 36,
    parameter logic [p_num_pipes-1:0][6:0] p_pipe_subsets = {p_num_pipes{7'h7f}}
) (
    input logic clk,
    input logic rst,
    decode_issue_rename_unit_if.master io
);
    localparam int P  = $clog2(p_num_phys_regs);
    localparam int FD = 1 << P;
    localparam int CW = P + 1;

    typedef enum logic [2:0] {OP_ADD, OP_MUL, OP_LW, OP_SW, OP_JAL, OP_JALR, OP_BNE} rv_uop_e;

    logic [P-1:0]                 map_tbl [32];
    logic [31:0]                  rf      [p_num_phys_regs];
    logic [p_num_phys_regs-1:0]   pending;
    logic [P-1:0]                 fl      [FD];
    logic [P-1:0]                 fl_head, fl_tail;
    logic [CW-1:0]                fl_cnt;

    logic [31:0] inst, imm_i, imm_s, imm_b, imm_j;
    logic [4:0]  rd, rs1, rs2;
    assign inst  = io.F_inst;
    assign rd    = inst[11:7];
    assign rs1   = inst[19:15];
    assign rs2   = inst[24:20];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    rv_uop_e uop;
    logic    uses_rs1, uses_rs2, writes;
    always_comb begin
        uop = OP_ADD; uses_rs1 = 1'b0; uses_rs2 = 1'b0; writes = 1'b0;
        case (inst[6:0])
            7'b0110011: begin uop = inst[25] ? OP_MUL : OP_ADD; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes = 1'b1; end
            7'b0010011: begin uop = OP_ADD;  uses_rs1 = 1'b1; writes = 1'b1; end
            7'b0000011: begin uop = OP_LW;   uses_rs1 = 1'b1; writes = 1'b1; end
            7'b0100011: begin uop = OP_SW;   uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1101111: begin uop = OP_JAL;  writes = 1'b1; end
            7'b1100111: begin uop = OP_JALR; uses_rs1 = 1'b1; writes = 1'b1; end
            7'b1100011: begin uop = OP_BNE;  uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default: ;
        endcase
    end

    // Same-cycle complete forwards into the operand read and clears the stall.
    logic         cpl_wr, hit1, hit2, pend1, pend2;
    logic [P-1:0] src1, src2;
    logic [31:0]  r1, r2;
    assign cpl_wr = io.complete_val & io.complete_wen & (io.complete_preg != '0);
    assign src1   = map_tbl[rs1];
    assign src2   = map_tbl[rs2];
    assign hit1   = cpl_wr && (io.complete_preg == src1);
    assign hit2   = cpl_wr && (io.complete_preg == src2);
    assign r1     = hit1 ? io.complete_wdata : rf[src1];
    assign r2     = hit2 ? io.complete_wdata : rf[src2];
    assign pend1  = uses_rs1 & pending[src1] & ~hit1;
    assign pend2  = uses_rs2 & pending[src2] & ~hit2;

    always_comb begin
        io.Ex_op1 = r1; io.Ex_op2 = r2; io.Ex_op3 = '0;
        case (uop)
            OP_ADD:         if (!uses_rs2) io.Ex_op2 = imm_i;
            OP_LW, OP_JALR: io.Ex_op2 = imm_i;
            OP_SW:          begin io.Ex_op2 = imm_s; io.Ex_op3 = r2; end
            OP_BNE:         io.Ex_op3 = io.F_pc + imm_b;
            OP_JAL:         begin io.Ex_op1 = io.F_pc + 32'd4; io.Ex_op2 = '0; end
            default: ;
        endcase
    end

    logic [6:0]             uop_vec;
    logic [p_num_pipes-1:0] cap_rdy, sel;
    assign uop_vec = 7'b1 << uop;
    for (genvar i = 0; i < p_num_pipes; i++) begin : g_pipe
        assign cap_rdy[i] = (|(p_pipe_subsets[i] & uop_vec)) & io.Ex_rdy[i];
    end
    assign sel = cap_rdy & (-cap_rdy);

    logic need_alloc, fl_empty, fire, alloc, push;
    assign need_alloc = writes & (rd != 5'd0);
    assign fl_empty   = (fl_cnt == '0);
    assign io.F_rdy   = ~rst & (|cap_rdy) & ~pend1 & ~pend2 & ~(need_alloc & fl_empty);
    assign fire       = io.F_val & io.F_rdy;
    assign alloc      = fire & need_alloc;
    assign push       = io.commit_val & io.commit_wen & (io.commit_ppreg != '0);

    assign io.Ex_val         = fire ? sel : '0;
    assign io.Ex_pc          = io.F_pc;
    assign io.Ex_seq_num     = io.F_seq_num;
    assign io.Ex_uop         = uop;
    assign io.Ex_waddr       = need_alloc ? rd : 5'd0;
    assign io.Ex_preg        = need_alloc ? fl[fl_head] : '0;
    assign io.Ex_ppreg       = need_alloc ? map_tbl[rd] : '0;
    assign io.squash_val     = fire & (uop == OP_JAL);
    assign io.squash_seq_num = io.F_seq_num;
    assign io.squash_target  = io.F_pc + imm_j;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) map_tbl[r] <= P'(r);
            for (int i = 0; i < p_num_phys_regs; i++) rf[i] <= '0;
            for (int i = 0; i < FD; i++) fl[i] <= (i < p_num_phys_regs - 32) ? P'(i + 32) : '0;
            pending <= '0;
            fl_head <= '0;
            fl_tail <= P'(p_num_phys_regs - 32);
            fl_cnt  <= CW'(p_num_phys_regs - 32);
        end else begin
            if (cpl_wr) begin
                rf[io.complete_preg]      <= io.complete_wdata;
                pending[io.complete_preg] <= 1'b0;
            end
            if (alloc) begin
                map_tbl[rd]           <= fl[fl_head];
                pending[fl[fl_head]]  <= 1'b1;
                fl_head               <= fl_head + P'(1);
            end
            if (push) begin
                fl[fl_tail] <= io.commit_ppreg;
                fl_tail     <= fl_tail + P'(1);
            end
            fl_cnt <= fl_cnt + CW'(push) - CW'(alloc);
        end
    end

    logic unused_ok;
    assign unused_ok = ^{inst[14:12], io.complete_seq_num, io.complete_waddr, io.commit_pc,
                         io.commit_seq_num, io.commit_waddr, io.commit_wdata};
endmodule

// File: tb/tb_decode_issue_rename_unit.sv
// Directed bench for decode_issue_rename_unit: rename, RAW stall/bypass, free-list
// exhaustion and reuse, pipe selection, JAL squash, store operands, mid-run reset.
module tb_decode_issue_rename_unit;
    localparam int P = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_rename_unit_if #(.p_num_pipes(3)) if0 ();
    decode_issue_rename_unit_if #(.p_num_pipes(2)) if1 ();

    decode_issue_rename_unit #(.p_num_pipes(3)) dut0 (.clk(clk), .rst(rst), .io(if0));
    decode_issue_rename_unit #(.p_num_pipes(2), .p_pipe_subsets({7'h01, 7'h7f}))
        dut1 (.clk(clk), .rst(rst), .io(if1));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rd, rs1, rs2, input logic [6:0] f7);
        logic [31:0] d = rd, s1 = rs1, s2 = rs2;
        return {f7, s2[4:0], s1[4:0], 3'b000, d[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] itype(input int rd, rs1, imm, input logic [2:0] f3, input logic [6:0] opc);
        logic [31:0] d = rd, s1 = rs1, m = imm;
        return {m[11:0], s1[4:0], f3, d[4:0], opc};
    endfunction
    function automatic logic [31:0] stype(input int rs2, rs1, imm);
        logic [31:0] s1 = rs1, s2 = rs2, m = imm;
        return {m[11:5], s2[4:0], s1[4:0], 3'b010, m[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] btype(input int rs1, rs2, imm);
        logic [31:0] s1 = rs1, s2 = rs2, m = imm;
        return {m[12], m[10:5], s2[4:0], s1[4:0], 3'b001, m[4:1], m[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jtype(input int rd, imm);
        logic [31:0] d = rd, m = imm;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc, input int seq);
        if0.F_val = 1'b1; if0.F_inst = inst; if0.F_pc = pc; if0.F_seq_num = 5'(seq); #1;
    endtask
    task automatic idle();
        if0.F_val = 1'b0;
    endtask
    task automatic cmpl(input int preg, input int wdata);
        if0.complete_val = 1'b1; if0.complete_wen = 1'b1;
        if0.complete_preg = P'(preg); if0.complete_wdata = wdata; #1;
    endtask
    task automatic commit(input int ppreg);
        if0.commit_val = 1'b1; if0.commit_wen = 1'b1; if0.commit_ppreg = P'(ppreg); #1;
    endtask
    task automatic clr_notif();
        if0.complete_val = 1'b0; if0.commit_val = 1'b0;
    endtask

    task automatic chk_ex(input string t, input logic [31:0] val, op1, op2, op3, wa, pr, ppr, uop);
        check({t, ".frdy"},  32'(if0.F_rdy), (val != 0) ? 32'd1 : 32'd0);
        check({t, ".val"},   32'(if0.Ex_val), val);
        check({t, ".op1"},   if0.Ex_op1, op1);
        check({t, ".op2"},   if0.Ex_op2, op2);
        check({t, ".op3"},   if0.Ex_op3, op3);
        check({t, ".waddr"}, 32'(if0.Ex_waddr), wa);
        check({t, ".preg"},  32'(if0.Ex_preg), pr);
        check({t, ".ppreg"}, 32'(if0.Ex_ppreg), ppr);
        check({t, ".uop"},   32'(if0.Ex_uop), uop);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        if0.F_val = 1'b0; if0.F_inst = '0; if0.F_pc = '0; if0.F_seq_num = '0; if0.Ex_rdy = 3'b111;
        if0.complete_val = 1'b0; if0.complete_seq_num = '0; if0.complete_waddr = '0;
        if0.complete_wdata = '0; if0.complete_wen = 1'b0; if0.complete_preg = '0;
        if0.commit_val = 1'b0; if0.commit_pc = '0; if0.commit_seq_num = '0; if0.commit_waddr = '0;
        if0.commit_wdata = '0; if0.commit_wen = 1'b0; if0.commit_ppreg = '0;
        if1.F_val = 1'b0; if1.F_inst = '0; if1.F_pc = '0; if1.F_seq_num = '0; if1.Ex_rdy = 2'b00;
        if1.complete_val = 1'b0; if1.complete_seq_num = '0; if1.complete_waddr = '0;
        if1.complete_wdata = '0; if1.complete_wen = 1'b0; if1.complete_preg = '0;
        if1.commit_val = 1'b0; if1.commit_pc = '0; if1.commit_seq_num = '0; if1.commit_waddr = '0;
        if1.commit_wdata = '0; if1.commit_wen = 1'b0; if1.commit_ppreg = '0;
        step(); step();

        // In reset nothing issues, even a JAL.
        fetch(jtype(1, 32'h10), 32'h100, 0);
        check("rst.frdy", 32'(if0.F_rdy), 0);
        check("rst.exval", 32'(if0.Ex_val), 0);
        check("rst.squash", 32'(if0.squash_val), 0);
        rst = 1'b0; idle(); step();

        fetch(itype(1, 0, 5, 3'b000, 7'b0010011), 32'h200, 0);
        chk_ex("addi", 1, 0, 5, 0, 1, 32, 1, 0);
        check("addi.squash", 32'(if0.squash_val), 0);
        check("addi.pc", if0.Ex_pc, 32'h200);
        step();

        fetch(rtype(2, 1, 1, 7'h00), 32'h204, 1);
        check("raw.stall0", 32'(if0.F_rdy), 0);
        check("raw.exval0", 32'(if0.Ex_val), 0);
        step();
        check("raw.stall1", 32'(if0.F_rdy), 0);
        cmpl(32, 5);
        chk_ex("raw.bypass", 1, 5, 5, 0, 2, 33, 2, 0);
        check("raw.seq", 32'(if0.Ex_seq_num), 1);
        step(); clr_notif();

        fetch(itype(3, 0, 7, 3'b000, 7'b0010011), 32'h208, 2);
        chk_ex("a3", 1, 0, 7, 0, 3, 34, 3, 0);
        step();
        fetch(itype(4, 0, 9, 3'b000, 7'b0010011), 32'h20c, 3);
        chk_ex("a4", 1, 0, 9, 0, 4, 35, 4, 0);
        step();

        // Free list now empty: fifth writer waits for a commit; same-cycle push stalls.
        fetch(itype(5, 0, 1, 3'b000, 7'b0010011), 32'h210, 4);
        check("fl.empty", 32'(if0.F_rdy), 0);
        commit(1);
        check("fl.pushpop", 32'(if0.F_rdy), 0);
        step(); clr_notif(); #1;
        chk_ex("fl.reuse", 1, 0, 1, 0, 5, 1, 5, 0);
        step();

        fetch(itype(6, 0, 3, 3'b000, 7'b0010011), 32'h214, 5);
        commit(0);
        step(); clr_notif(); #1;
        check("fl.pp0", 32'(if0.F_rdy), 0);
        commit(2);
        step(); clr_notif(); #1;
        chk_ex("a6", 1, 0, 3, 0, 6, 2, 6, 0);
        step();

        idle();
        cmpl(33, 10); step();
        cmpl(34, 7);  step();
        cmpl(35, 9);  step();
        clr_notif();
        commit(3); step(); clr_notif();

        fetch(jtype(1, 32'h10), 32'h100, 31);
        chk_ex("jal", 1, 32'h104, 0, 0, 1, 3, 32, 4);
        check("jal.sqval", 32'(if0.squash_val), 1);
        check("jal.sqseq", 32'(if0.squash_seq_num), 31);
        check("jal.sqtgt", if0.squash_target, 32'h110);
        step();

        idle(); commit(4); step(); clr_notif();
        if0.Ex_rdy = 3'b110;
        fetch(rtype(7, 3, 4, 7'h01), 32'h104, 0);
        chk_ex("mul.pipe1", 2, 7, 9, 0, 7, 4, 7, 1);
        check("mul.seqwrap", 32'(if0.Ex_seq_num), 0);
        check("mul.squash", 32'(if0.squash_val), 0);
        step();

        idle(); commit(5); step(); clr_notif();
        if0.Ex_rdy = 3'b000;
        fetch(stype(3, 2, 4), 32'h108, 1);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            check("sw.hold", 32'(if0.F_rdy), 0);
            check("sw.holdval", 32'(if0.Ex_val), 0);
            step();
        end
        if0.Ex_rdy = 3'b100; #1;
        chk_ex("sw", 4, 10, 4, 7, 0, 0, 0, 3);
        step();
        if0.Ex_rdy = 3'b111;

        // sw must not have popped: this writer still gets preg 5.
        fetch(itype(8, 0, -1, 3'b000, 7'b0010011), 32'h10c, 2);
        chk_ex("a8", 1, 0, 32'hffffffff, 0, 8, 5, 8, 0);
        step();
        fetch(itype(0, 3, -4, 3'b010, 7'b0000011), 32'h110, 3);
        chk_ex("lw.x0", 1, 7, 32'hfffffffc, 0, 0, 0, 0, 2);
        step();
        fetch(btype(3, 4, 8), 32'h300, 4);
        chk_ex("bne", 1, 7, 9, 32'h308, 0, 0, 0, 6);
        step();

        fetch(rtype(10, 8, 8, 7'h00), 32'h304, 5);
        check("pend.x8", 32'(if0.F_rdy), 0);
        rst = 1'b1; step(); rst = 1'b0; #1;
        chk_ex("rst.mid", 1, 0, 0, 0, 10, 32, 10, 0);
        step(); idle();

        // Pipe1 only takes adds; mul must wait for pipe0.
        if1.Ex_rdy = 2'b10; if1.F_val = 1'b1; if1.F_inst = rtype(5, 0, 0, 7'h00); #1;
        check("sub.add", 32'(if1.Ex_val), 2);
        step();
        if1.F_inst = rtype(6, 0, 0, 7'h01); #1;
        check("sub.mulwait0", 32'(if1.F_rdy), 0);
        step();
        check("sub.mulwait1", 32'(if1.F_rdy), 0);
        if1.Ex_rdy = 2'b11; #1;
        check("sub.mul", 32'(if1.Ex_val), 1);
        step(); if1.F_val = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_issue_rename_unit.md
Name: decode_issue_rename_unit

Overview:
- Decode/rename/issue stage between fetch (F) and the execute pipes (X) of the out-of-order TinyRV1 core.
- Decodes one instruction per cycle and renames its destination to a free physical register.
- Reads operands from a physical register file and issues to the lowest-index capable execute pipe.
- Consumes complete notifications (register-file writes) and commit notifications (freeing physical registers); emits a squash notification for JAL redirects.

Parameters:
- p_num_pipes, 3: number of execute pipes.
- p_seq_num_bits, 5: sequence-number width.
- p_num_phys_regs, 36: physical register count; must be greater than 32. P = clog2(p_num_phys_regs).
- p_pipe_subsets, all p_tinyrv1: per-pipe rv_op_vec bitmask of the uops that pipe accepts.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- F_val, F_rdy  in/out  1/1  fetch handshake.
- F_inst, F_pc, F_seq_num  in  32/32/p_seq_num_bits  fetched instruction.
- Ex_val[i], Ex_rdy[i]  out/in  1/1  per-pipe handshake (D__XIntf).
- Ex_pc, Ex_seq_num, Ex_op1, Ex_op2, Ex_op3  out  32/seq/32/32/32  issued payload.
- Ex_waddr, Ex_preg, Ex_ppreg, Ex_uop  out  5/P/P/rv_uop  destination and rename info.
- complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen, complete_preg  in  1/seq/5/32/1/P  CompleteNotif.
- commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata, commit_wen, commit_ppreg  in  1/32/seq/5/32/1/P  CommitNotif.
- squash_val, squash_seq_num, squash_target  out  1/seq/32  SquashNotif.

Behaviour:
- Reset:
  - Map table arch r -> phys r.
  - Phys 0..31 hold 0 and are not pending.
  - Free list FIFO holds 32..N-1 in ascending order.
  - All Ex_val = 0, squash_val = 0.
- Decode and uop mapping:
  - add/addi -> OP_ADD; mul -> OP_MUL; lw -> OP_LW; sw -> OP_SW; jal -> OP_JAL; jalr -> OP_JALR; bne -> OP_BNE.
- Operands:
  - add/mul/bne: op1 = R[rs1], op2 = R[rs2].
  - addi/lw/jalr: op1 = R[rs1], op2 = sext(imm).
  - sw: op1 = R[rs1], op2 = sext(imm), op3 = R[rs2].
  - bne: op3 = pc + B-imm.
  - jal: op1 = pc + 4, op2 = 0.
  - Otherwise op3 = 0.
- Rename, for an instruction writing rd != 0:
  - preg = head of free list (popped on issue); ppreg = old map[rd].
  - map[rd] <= preg; pending[preg] <= 1; waddr = rd.
- Non-writing instructions (sw, bne) and rd = x0: waddr = 0, preg = 0, ppreg = 0, no allocation.
- Issue: combinational and fully pipelined, 0-cycle latency from F_val to Ex_val. Fire = F_val & F_rdy.
- Pipe select: lowest i with p_pipe_subsets[i] & uop-vector nonzero and Ex_rdy[i]; only that pipe's Ex_val is asserted.
- F_rdy = 1 only when all of the following hold:
  - a capable pipe is ready;
  - no source phys reg is pending;
  - free list non-empty (when allocation is needed);
  - not in reset.
  Otherwise stall: hold the instruction, Ex_val = 0.
- Complete (val & wen): R[preg] <= wdata, pending[preg] <= 0. A same-cycle complete bypasses into operand read and unblocks the stall.
- Commit (val & wen & ppreg != 0): push ppreg onto free-list tail. Same-cycle push and pop on an empty list stalls one cycle.
- JAL fire: squash_val = 1 that cycle, squash_seq_num = F_seq_num, squash_target = pc + J-imm. Otherwise squash_val = 0.
- Reg x0 always reads 0, is never renamed, and never goes pending.
- Sequence numbers pass through unchanged and wrap modulo 2^p_seq_num_bits.
- Reset mid-operation restores all state on the next edge; in-flight pending bits are discarded.

Test Plan:
- After reset, addi x1,x0,5 @pc 0x200, seq 0 -> pipe0: op1 0, op2 5, waddr 1, preg 32, ppreg 1, uop OP_ADD.
- Then add x2,x1,x1 -> stalls (F_rdy = 0) until complete(seq 0, preg 32, wdata 5) -> issues op1 5, op2 5, preg 33, ppreg 2.
- Allocate 4 regs with p_num_phys_regs = 36 -> 5th writer stalls; commit(wen 1, ppreg 1) -> issues with preg 1.
- Pipes {p_tinyrv1, OP_ADD_VEC} with pipe1 rdy only -> add goes to pipe1, mul waits for pipe0.
- jal x1,0x10 @pc 0x100 -> op1 0x104, squash_val 1, squash_target 0x110.
- Ex_rdy toggling with random delays and sw x3,4(x2) -> op2 4, op3 = R[x3], waddr 0, preg 0, no allocation.
